fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO, running entirely in the write clock domain. It turns producer write requests into the write address, write enable qualification, and full flag that the FIFO storage array consumes. It also publishes a Gray-coded write pointer to the read domain. It synchronizes the read domain's Gray pointer back to derive full, almost-full, fill level, and a sticky overflow flag.

---
 rtl/fifo_wr_ctrl.sv | 72 +++++++
 tb/tb_fifo_wr_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: binary+Gray write
// pointer, two-flop read-pointer synchronizer, registered full/almost-full/level.
module fifo_wr_ctrl #(
   parameter int A_SIZE    = 3,
   parameter int P_SIZE    = 4,
   parameter int AF_THRESH = 6
) (
   input  logic              w_clk,
   input  logic              w_rstn,
   input  logic              w_inc,
   input  logic              w_ovf_clr,
   input  logic [P_SIZE-1:0] r_ptr_gray,
   output logic [A_SIZE-1:0] w_addr,
   output logic [P_SIZE-1:0] w_ptr_gray,
   output logic              w_full,
   output logic              w_almost_full,
   output logic [P_SIZE-1:0] w_level,
   output logic              w_overflow
);

   localparam logic [P_SIZE-1:0] AF_T = P_SIZE'(AF_THRESH);

   logic [P_SIZE-1:0] wbin, wbin_next, wgray_next;
   logic [P_SIZE-1:0] rq1, rq2, rbin, level_next, full_pat;
   logic              accept;

   assign accept     = w_inc & ~w_full;
   assign wbin_next  = wbin + {{(P_SIZE-1){1'b0}}, accept};
   assign wgray_next = wbin_next ^ (wbin_next >> 1);
   assign w_addr     = wbin[A_SIZE-1:0];

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin = '0;
      for (int i = 0; i < P_SIZE; i++)
         rbin[i] = ^(rq2 >> i);
   end

   assign level_next = wbin_next - rbin;
   // Full when the write pointer is one lap ahead: top two Gray bits inverted.
   assign full_pat   = {~rq2[P_SIZE-1:P_SIZE-2], rq2[P_SIZE-3:0]};

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         rq1 <= '0;
         rq2 <= '0;
      end else begin
         rq1 <= r_ptr_gray;
         rq2 <= rq1;
      end
   end

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         wbin          <= '0;
         w_ptr_gray    <= '0;
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_level       <= '0;
         w_overflow    <= 1'b0;
      end else begin
         wbin          <= wbin_next;
         w_ptr_gray    <= wgray_next;
         w_full        <= (wgray_next == full_pat);
         w_almost_full <= (level_next >= AF_T);
         w_level       <= level_next;
         // Set has priority over clear so a same-cycle overflow is never lost.
         w_overflow    <= (w_inc & w_full) | (w_overflow & ~w_ovf_clr);
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed vector table, randomized run against a
// count-based reference model, wrap-around stream and mid-burst reset.
module tb_fifo_wr_ctrl;

   logic       w_clk = 1'b0;
   logic       w_rstn = 1'b0;
   logic       w_inc = 1'b0;
   logic       w_ovf_clr = 1'b0;
   logic [3:0] r_ptr_gray = '0;
   logic [2:0] w_addr;
   logic [3:0] w_ptr_gray;
   logic       w_full, w_almost_full, w_overflow;
   logic [3:0] w_level;

   int n_chk = 0;
   int n_fail = 0;

   // reference model: absolute write count and history of sampled read pointers
   int  wcnt, rh0, rh1, mlevel;
   bit  mfull, movf;

   fifo_wr_ctrl #(.A_SIZE(3), .P_SIZE(4), .AF_THRESH(6)) dut (
      .w_clk(w_clk), .w_rstn(w_rstn), .w_inc(w_inc), .w_ovf_clr(w_ovf_clr),
      .r_ptr_gray(r_ptr_gray), .w_addr(w_addr), .w_ptr_gray(w_ptr_gray),
      .w_full(w_full), .w_almost_full(w_almost_full), .w_level(w_level),
      .w_overflow(w_overflow)
   );

   always #5 w_clk = ~w_clk;

   typedef struct {
      logic       inc, clr;
      logic [3:0] rg;
      logic [2:0] addr;
      logic [3:0] gray, lvl;
      logic       full, af, ovf;
   } vec_t;

   vec_t tbl[20];

   function automatic int to_gray(int b);
      int m = b % 16;
      return (m ^ (m >> 1)) & 15;
   endfunction

   function automatic int from_gray(int gy);
      int b = 0;
      for (int i = 3; i >= 0; i--)
         b |= (((b >> (i + 1)) & 1) ^ ((gy >> i) & 1)) << i;
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      wcnt = 0; rh0 = 0; rh1 = 0; mlevel = 0; mfull = 0; movf = 0;
   endtask

   // Drive one cycle of inputs, clock it, advance the model, and check the
   // full/level consistency that must hold every cycle.
   task automatic apply(input bit inc, input bit clr, input int rg);
      bit acc;
      w_inc = inc; w_ovf_clr = clr; r_ptr_gray = 4'(rg);
      @(posedge w_clk); #1;
      acc    = inc && !mfull;
      movf   = (inc && mfull) || (movf && !clr);
      wcnt   = wcnt + (acc ? 1 : 0);
      mlevel = (((wcnt - rh1) % 16) + 16) % 16;
      rh1    = rh0;
      rh0    = from_gray(rg);
      mfull  = (mlevel == 8);
      chk("full_vs_level_invariant", w_full, (w_level == 4'd8));
   endtask

   task automatic check_model(input string tag);
      chk({tag, " addr"},  w_addr,        wcnt % 8);
      chk({tag, " gray"},  w_ptr_gray,    to_gray(wcnt));
      chk({tag, " level"}, w_level,       mlevel);
      chk({tag, " full"},  w_full,        mfull);
      chk({tag, " afull"}, w_almost_full, mlevel >= 6);
      chk({tag, " ovf"},   w_overflow,    movf);
   endtask

   task automatic do_reset();
      w_rstn = 1'b0; w_inc = 0; w_ovf_clr = 0; r_ptr_gray = 0;
      model_reset();
      repeat (2) @(posedge w_clk);
      #3 w_rstn = 1'b1;
   endtask

   initial begin
      int rp, prev_gray;
      int hist[$];

      //          inc clr rg  addr gray lvl full af ovf
      tbl[0]  = '{1, 0, 4'h0, 3'd1, 4'h1, 4'd1, 0, 0, 0};
      tbl[1]  = '{1, 0, 4'h0, 3'd2, 4'h3, 4'd2, 0, 0, 0};
      tbl[2]  = '{1, 0, 4'h0, 3'd3, 4'h2, 4'd3, 0, 0, 0};
      tbl[3]  = '{1, 0, 4'h0, 3'd4, 4'h6, 4'd4, 0, 0, 0};
      tbl[4]  = '{1, 0, 4'h0, 3'd5, 4'h7, 4'd5, 0, 0, 0};
      tbl[5]  = '{1, 0, 4'h0, 3'd6, 4'h5, 4'd6, 0, 1, 0};
      tbl[6]  = '{1, 0, 4'h0, 3'd7, 4'h4, 4'd7, 0, 1, 0};
      tbl[7]  = '{1, 0, 4'h0, 3'd0, 4'hC, 4'd8, 1, 1, 0};
      tbl[8]  = '{1, 0, 4'h0, 3'd0, 4'hC, 4'd8, 1, 1, 1};  // write while full
      tbl[9]  = '{0, 0, 4'h0, 3'd0, 4'hC, 4'd8, 1, 1, 1};  // sticky
      tbl[10] = '{1, 1, 4'h0, 3'd0, 4'hC, 4'd8, 1, 1, 1};  // set beats clear
      tbl[11] = '{0, 1, 4'h0, 3'd0, 4'hC, 4'd8, 1, 1, 0};
      tbl[12] = '{0, 0, 4'h2, 3'd0, 4'hC, 4'd8, 1, 1, 0};  // read ptr 3 arrives
      tbl[13] = '{0, 0, 4'h2, 3'd0, 4'hC, 4'd8, 1, 1, 0};
      tbl[14] = '{0, 0, 4'h2, 3'd0, 4'hC, 4'd5, 0, 0, 0};
      tbl[15] = '{1, 0, 4'h2, 3'd1, 4'hD, 4'd6, 0, 1, 0};
      tbl[16] = '{1, 0, 4'h2, 3'd2, 4'hF, 4'd7, 0, 1, 0};
      tbl[17] = '{0, 0, 4'h6, 3'd2, 4'hF, 4'd7, 0, 1, 0};  // read ptr 4 in flight
      tbl[18] = '{0, 0, 4'h6, 3'd2, 4'hF, 4'd7, 0, 1, 0};
      tbl[19] = '{1, 0, 4'h6, 3'd3, 4'hE, 4'd7, 0, 1, 0};  // write + read together

      do_reset();
      chk("reset addr",  w_addr, 0);
      chk("reset gray",  w_ptr_gray, 0);
      chk("reset level", w_level, 0);
      chk("reset full",  w_full, 0);
      chk("reset afull", w_almost_full, 0);
      chk("reset ovf",   w_overflow, 0);

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].inc, tbl[i].clr, tbl[i].rg);
         chk($sformatf("vec%0d addr", i),  w_addr,        tbl[i].addr);
         chk($sformatf("vec%0d gray", i),  w_ptr_gray,    tbl[i].gray);
         chk($sformatf("vec%0d level", i), w_level,       tbl[i].lvl);
         chk($sformatf("vec%0d full", i),  w_full,        tbl[i].full);
         chk($sformatf("vec%0d afull", i), w_almost_full, tbl[i].af);
         chk($sformatf("vec%0d ovf", i),   w_overflow,    tbl[i].ovf);
      end

      // randomized traffic; the read side only consumes what has been written
      do_reset();
      rp = 0;
      for (int c = 0; c < 400; c++) begin
         bit inc, clr;
         inc = ($urandom_range(0, 3) != 0) ^ (c[6] & ($urandom_range(0, 1) == 1));
         clr = ($urandom_range(0, 7) == 0);
         if (rp < wcnt && $urandom_range(0, 2) == 0) rp++;
         apply(inc, clr, to_gray(rp));
         check_model("rand");
      end

      // wrap-around stream with the read pointer trailing the writes
      do_reset();
      prev_gray = 0;
      for (int c = 0; c < 40; c++) begin
         hist.push_back(wcnt);
         apply(1, 0, (hist.size() >= 2) ? to_gray(hist[hist.size() - 2]) : 0);
         check_model("wrap");
         chk("wrap full_low", w_full, 0);
         chk("wrap level_le4", (w_level <= 4'd4), 1);
         chk("wrap gray_1bit", $countones(4'(prev_gray) ^ w_ptr_gray), 1);
         prev_gray = int'(w_ptr_gray);
      end

      // reset asserted mid-burst with a write pending
      for (int c = 0; c < 3; c++) apply(1, 0, 0);
      w_inc = 1; #3 w_rstn = 1'b0; #1;
      model_reset();
      chk("async_rst addr",  w_addr, 0);
      chk("async_rst gray",  w_ptr_gray, 0);
      chk("async_rst level", w_level, 0);
      chk("async_rst full",  w_full, 0);
      chk("async_rst afull", w_almost_full, 0);
      chk("async_rst ovf",   w_overflow, 0);
      r_ptr_gray = 0;
      repeat (2) @(posedge w_clk);
      #3 w_rstn = 1'b1;
      chk("post_rst addr", w_addr, 0);
      apply(1, 0, 0);
      check_model("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
